// File: rtl/ofm_writeback_if.sv
// Signal bundle between the systolic drain, the writeback block and the OFM RAM write port.
// The block uses the slave view; the producer/RAM side uses the master view.
interface ofm_writeback_if #(
   parameter int INOUT_WIDTH  = 1024,
   parameter int OFM_RAM_SIZE = 2378675
);
   localparam int AW = $clog2(OFM_RAM_SIZE);

   logic                   in_valid;
   logic [INOUT_WIDTH-1:0] in_data;
   logic                   in_ready;
   logic                   ofm_read_en;
   logic                   write_out_ofm_en;
   logic [AW-1:0]          ofm_addr_b;
   logic [INOUT_WIDTH-1:0] ofm_data_in;

   modport master (
      output in_valid,
      output in_data,
      output ofm_read_en,
      input  in_ready,
      input  write_out_ofm_en,
      input  ofm_addr_b,
      input  ofm_data_in
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  ofm_read_en,
      output in_ready,
      output write_out_ofm_en,
      output ofm_addr_b,
      output ofm_data_in
   );
endinterface

// File: rtl/ofm_writeback.sv
// Output-feature-map writeback: activates systolic drain words, buffers them in a small FIFO
// and writes them into the OFM RAM at strided addresses, yielding the port to reads.
module ofm_writeback #(
   parameter int SYSTOLIC_SIZE = 16,
   parameter int DATA_WIDTH    = 64,
   parameter int INOUT_WIDTH   = 1024,
   parameter int OFM_RAM_SIZE  = 2378675,
   parameter int RELU_PARAM    = 0,
   localparam int AW           = $clog2(OFM_RAM_SIZE)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [AW-1:0]        base_addr,
   input  logic [AW-1:0]        addr_stride,
   input  logic [15:0]          num_words,
   ofm_writeback_if.slave       bus,
   output logic                 busy,
   output logic                 done,
   output logic                 addr_err
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam int FIFO_DEPTH = 4;
   localparam logic [AW:0] RAM_LIMIT = OFM_RAM_SIZE[AW:0];
   localparam logic [AW:0] LANES_W   = SYSTOLIC_SIZE[AW:0];

   logic [1:0]             state_q, state_d;
   logic [15:0]            numWords_q, numWords_d;
   logic [15:0]            acceptCount_q, acceptCount_d;
   logic [15:0]            writeCount_q, writeCount_d;
   logic [AW-1:0]          stride_q, stride_d;
   logic [AW:0]            addr_q, addr_d;
   logic                   addrErr_q, addrErr_d;
   logic                   pipeValid_q, pipeValid_d;
   logic [INOUT_WIDTH-1:0] pipeData_q, pipeData_d;
   logic [INOUT_WIDTH-1:0] fifoMem_q [FIFO_DEPTH];
   logic [1:0]             rdPtr_q, rdPtr_d;
   logic [1:0]             wrPtr_q, wrPtr_d;
   logic [2:0]             fifoCount_q, fifoCount_d;
   logic                   wrEn_q, wrEn_d;
   logic [AW-1:0]          addrOut_q, addrOut_d;
   logic [INOUT_WIDTH-1:0] dataOut_q, dataOut_d;

   logic                   startAccept;
   logic                   inReady;
   logic                   accept;
   logic [2:0]             inFlight;
   logic                   fifoEmpty;
   logic                   haveHead;
   logic [INOUT_WIDTH-1:0] headData;
   logic                   pop;
   logic                   popFifo;
   logic                   push;
   logic [AW:0]            addrEnd;
   logic                   addrFits;
   logic                   issue;
   logic [INOUT_WIDTH-1:0] actData;

   function automatic logic [DATA_WIDTH-1:0] activate(input logic [DATA_WIDTH-1:0] x);
      logic signed [DATA_WIDTH-1:0] v;
      v = $signed(x);
      if (!v[DATA_WIDTH-1]) begin
         return x;
      end
      if (RELU_PARAM == 0) begin
         return '0;
      end
      return v >>> RELU_PARAM;
   endfunction

   always_comb begin
      actData = '0;
      for (int i = 0; i < SYSTOLIC_SIZE; i++) begin
         actData[i*DATA_WIDTH +: DATA_WIDTH] = activate(bus.in_data[i*DATA_WIDTH +: DATA_WIDTH]);
      end
   end

   // Words in flight count both the activation register and the FIFO, so the FIFO can never overflow.
   assign startAccept = start && (state_q == IDLE);
   assign inFlight    = fifoCount_q + {2'b00, pipeValid_q};
   assign inReady     = (state_q == RUN) && (inFlight < 3'd4);
   assign accept      = bus.in_valid && inReady;

   // An empty FIFO is bypassed so a freshly activated word can be written straight away.
   assign fifoEmpty = (fifoCount_q == 3'd0);
   assign haveHead  = !fifoEmpty || pipeValid_q;
   assign headData  = fifoEmpty ? pipeData_q : fifoMem_q[rdPtr_q];
   assign pop       = haveHead && !bus.ofm_read_en;
   assign popFifo   = pop && !fifoEmpty;
   assign push      = pipeValid_q && !(pop && fifoEmpty);

   assign addrEnd  = addr_q + LANES_W;
   assign addrFits = (addrEnd <= RAM_LIMIT);
   assign issue    = pop && addrFits;

   always_comb begin
      state_d       = state_q;
      numWords_d    = numWords_q;
      acceptCount_d = acceptCount_q;
      writeCount_d  = writeCount_q;
      stride_d      = stride_q;
      addr_d        = addr_q;
      addrErr_d     = addrErr_q;
      pipeValid_d   = accept;
      pipeData_d    = accept ? actData : pipeData_q;
      rdPtr_d       = rdPtr_q;
      wrPtr_d       = wrPtr_q;
      fifoCount_d   = fifoCount_q;
      wrEn_d        = issue;
      addrOut_d     = addrOut_q;
      dataOut_d     = dataOut_q;

      if (push) begin
         wrPtr_d = wrPtr_q + 2'd1;
      end
      if (popFifo) begin
         rdPtr_d = rdPtr_q + 2'd1;
      end
      fifoCount_d = fifoCount_q + {2'b00, push} - {2'b00, popFifo};

      if (accept) begin
         acceptCount_d = acceptCount_q + 16'd1;
      end

      // A suppressed write still counts as consumed so the transfer can finish.
      if (pop) begin
         writeCount_d = writeCount_q + 16'd1;
         if (!addrFits) begin
            addrErr_d = 1'b1;
         end
      end
      if (issue) begin
         addrOut_d = addr_q[AW-1:0];
         dataOut_d = headData;
         addr_d    = addr_q + {1'b0, stride_q};
      end

      if (startAccept) begin
         numWords_d    = num_words;
         stride_d      = addr_stride;
         addr_d        = {1'b0, base_addr};
         acceptCount_d = '0;
         writeCount_d  = '0;
         addrErr_d     = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = (num_words == 16'd0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (accept && (acceptCount_q == numWords_q - 16'd1)) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if ((writeCount_q == numWords_q) && !haveHead) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q       <= IDLE;
         numWords_q    <= '0;
         acceptCount_q <= '0;
         writeCount_q  <= '0;
         stride_q      <= '0;
         addr_q        <= '0;
         addrErr_q     <= 1'b0;
         pipeValid_q   <= 1'b0;
         pipeData_q    <= '0;
         rdPtr_q       <= '0;
         wrPtr_q       <= '0;
         fifoCount_q   <= '0;
         wrEn_q        <= 1'b0;
         addrOut_q     <= '0;
         dataOut_q     <= '0;
      end else begin
         state_q       <= state_d;
         numWords_q    <= numWords_d;
         acceptCount_q <= acceptCount_d;
         writeCount_q  <= writeCount_d;
         stride_q      <= stride_d;
         addr_q        <= addr_d;
         addrErr_q     <= addrErr_d;
         pipeValid_q   <= pipeValid_d;
         pipeData_q    <= pipeData_d;
         rdPtr_q       <= rdPtr_d;
         wrPtr_q       <= wrPtr_d;
         fifoCount_q   <= fifoCount_d;
         wrEn_q        <= wrEn_d;
         addrOut_q     <= addrOut_d;
         dataOut_q     <= dataOut_d;
      end
   end

   // Storage needs no reset: validity is carried entirely by the FIFO count.
   always_ff @(posedge clk) begin
      if (push) begin
         fifoMem_q[wrPtr_q] <= pipeData_q;
      end
   end

   assign bus.in_ready         = inReady;
   assign bus.write_out_ofm_en = wrEn_q;
   assign bus.ofm_addr_b       = addrOut_q;
   assign bus.ofm_data_in      = dataOut_q;
   assign busy                 = (state_q != IDLE);
   assign done                 = (state_q == DONE);
   assign addr_err             = addrErr_q;

endmodule

// File: tb/tb_ofm_writeback.sv
// Directed bench for ofm_writeback: two instances (plain ReLU and shift-2 leaky ReLU)
// share one stimulus stream; expected values are hand-computed constants.
module tb_ofm_writeback;

   localparam int AW = 22;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic [AW-1:0]     baseAddr = '0;
   logic [AW-1:0]     stride = '0;
   logic [15:0]       numWords = '0;
   logic              inValid = 1'b0;
   logic [1023:0]     inData = '0;
   logic              readEn = 1'b0;
   logic              busy0, done0, err0;
   logic              busy2, done2, err2;

   int compareCount = 0;
   int failCount = 0;

   ofm_writeback_if #(.INOUT_WIDTH(1024), .OFM_RAM_SIZE(2378675)) bus0 ();
   ofm_writeback_if #(.INOUT_WIDTH(1024), .OFM_RAM_SIZE(2378675)) bus2 ();

   assign bus0.in_valid    = inValid;
   assign bus0.in_data     = inData;
   assign bus0.ofm_read_en = readEn;
   assign bus2.in_valid    = inValid;
   assign bus2.in_data     = inData;
   assign bus2.ofm_read_en = readEn;

   ofm_writeback #(.RELU_PARAM(0)) dutRelu0 (
      .clk(clk), .rst_n(rst), .start(start), .base_addr(baseAddr), .addr_stride(stride),
      .num_words(numWords), .bus(bus0), .busy(busy0), .done(done0), .addr_err(err0)
   );

   ofm_writeback #(.RELU_PARAM(2)) dutRelu2 (
      .clk(clk), .rst_n(rst), .start(start), .base_addr(baseAddr), .addr_stride(stride),
      .num_words(numWords), .bus(bus2), .busy(busy2), .done(done2), .addr_err(err2)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      compareCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [AW-1:0] b, input logic [AW-1:0] s, input logic [15:0] n);
      baseAddr = b;
      stride   = s;
      numWords = n;
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   function automatic logic [1023:0] mkWord(input longint l0, input longint l1, input longint l2, input longint l3);
      logic [1023:0] w;
      w = '0;
      w[63:0]    = l0;
      w[127:64]  = l1;
      w[191:128] = l2;
      w[255:192] = l3;
      return w;
   endfunction

   function automatic logic [63:0] lane(input logic [1023:0] w, input int i);
      return w[i*64 +: 64];
   endfunction

   initial begin
      int  sendIdx;
      int  wIdx;
      logic prevReadEn;
      logic accepted;
      bit  sawStall;
      bit  sawDone;

      // Reset state
      tick();
      tick();
      checkOutput("rst_in_ready", bus0.in_ready, 1'b0);
      checkOutput("rst_wr_en", bus0.write_out_ofm_en, 1'b0);
      checkOutput("rst_addr", bus0.ofm_addr_b, 0);
      checkOutput("rst_data", lane(bus0.ofm_data_in, 0), 0);
      checkOutput("rst_busy", busy0, 1'b0);
      checkOutput("rst_done", done0, 1'b0);
      checkOutput("rst_err", err0, 1'b0);
      rst = 1'b0;
      tick();

      // Basic three-word run, continuous valid
      applyStimulus(22'd1162176, 22'd16, 16'd3);
      checkOutput("basic_busy", busy0, 1'b1);
      checkOutput("basic_in_ready", bus0.in_ready, 1'b1);
      inValid = 1'b1;
      inData  = mkWord(1, -3, 0, 0);
      for (int t = 1; t <= 6; t++) begin
         tick();
         if (t < 3) inData = mkWord(t + 1, -(t + 3), 0, 0);
         else inValid = 1'b0;
         checkOutput($sformatf("basic_wr_en_t%0d", t), bus0.write_out_ofm_en, (t >= 2 && t <= 4));
         if (t >= 2 && t <= 4) begin
            checkOutput($sformatf("basic_addr_t%0d", t), bus0.ofm_addr_b, 1162176 + (t - 2) * 16);
            checkOutput($sformatf("basic_lane0_t%0d", t), lane(bus0.ofm_data_in, 0), t - 1);
            checkOutput($sformatf("basic_lane1_t%0d", t), lane(bus0.ofm_data_in, 1), 0);
         end
         checkOutput($sformatf("basic_done_t%0d", t), done0, (t == 5));
         if (t == 3) checkOutput("basic_drain_in_ready", bus0.in_ready, 1'b0);
      end
      checkOutput("basic_idle", busy0, 1'b0);

      // Activation on both instances
      applyStimulus(22'd0, 22'd16, 16'd1);
      inValid = 1'b1;
      inData  = mkWord(5, -8, 0, -1);
      tick();
      inValid = 1'b0;
      tick();
      checkOutput("act_wr_en_r0", bus0.write_out_ofm_en, 1'b1);
      checkOutput("act_r0_lane0", lane(bus0.ofm_data_in, 0), 5);
      checkOutput("act_r0_lane1", lane(bus0.ofm_data_in, 1), 0);
      checkOutput("act_r0_lane2", lane(bus0.ofm_data_in, 2), 0);
      checkOutput("act_r0_lane3", lane(bus0.ofm_data_in, 3), 0);
      checkOutput("act_wr_en_r2", bus2.write_out_ofm_en, 1'b1);
      checkOutput("act_r2_lane0", lane(bus2.ofm_data_in, 0), 5);
      checkOutput("act_r2_lane1", lane(bus2.ofm_data_in, 1), -2);
      checkOutput("act_r2_lane2", lane(bus2.ofm_data_in, 2), 0);
      checkOutput("act_r2_lane3", lane(bus2.ofm_data_in, 3), -1);
      tick();
      checkOutput("act_done", done0, 1'b1);
      tick();

      // Read arbitration during a ten-word stream
      applyStimulus(22'd5000, 22'd32, 16'd10);
      sendIdx    = 0;
      wIdx       = 0;
      prevReadEn = 1'b0;
      sawStall   = 1'b0;
      sawDone    = 1'b0;
      inValid    = 1'b1;
      inData     = mkWord(1, -3, 0, 0);
      for (int c = 0; c < 60 && !sawDone; c++) begin
         readEn = (c >= 3 && c < 9);
         if (bus0.write_out_ofm_en) begin
            checkOutput($sformatf("arb_read_gap_w%0d", wIdx), prevReadEn, 1'b0);
            checkOutput($sformatf("arb_addr_w%0d", wIdx), bus0.ofm_addr_b, 5000 + wIdx * 32);
            checkOutput($sformatf("arb_lane0_w%0d", wIdx), lane(bus0.ofm_data_in, 0), wIdx + 1);
            wIdx++;
         end
         if (!bus0.in_ready && sendIdx < 10 && !sawStall) begin
            sawStall = 1'b1;
            checkOutput("arb_buffered_at_stall", sendIdx - wIdx, 4);
         end
         if (done0) sawDone = 1'b1;
         accepted   = inValid && bus0.in_ready;
         prevReadEn = readEn;
         tick();
         if (accepted) begin
            sendIdx++;
            if (sendIdx < 10) inData = mkWord(sendIdx + 1, -(sendIdx + 3), 0, 0);
            else inValid = 1'b0;
         end
      end
      readEn = 1'b0;
      checkOutput("arb_accepted", sendIdx, 10);
      checkOutput("arb_written", wIdx, 10);
      checkOutput("arb_stall_seen", sawStall, 1'b1);
      checkOutput("arb_done_seen", sawDone, 1'b1);
      tick();

      // Zero-length transfer
      applyStimulus(22'd0, 22'd16, 16'd0);
      checkOutput("zero_done", done0, 1'b1);
      checkOutput("zero_wr_en", bus0.write_out_ofm_en, 1'b0);
      tick();
      checkOutput("zero_done_clear", done0, 1'b0);
      checkOutput("zero_idle", busy0, 1'b0);

      // Address overrun at the top of the RAM
      applyStimulus(22'd2378659, 22'd16, 16'd2);
      inValid = 1'b1;
      inData  = mkWord(1, -3, 0, 0);
      for (int t = 1; t <= 5; t++) begin
         tick();
         if (t < 2) inData = mkWord(2, -4, 0, 0);
         else inValid = 1'b0;
         checkOutput($sformatf("ovr_wr_en_t%0d", t), bus0.write_out_ofm_en, (t == 2));
         if (t == 2) checkOutput("ovr_addr", bus0.ofm_addr_b, 2378659);
         checkOutput($sformatf("ovr_err_t%0d", t), err0, (t >= 3));
         checkOutput($sformatf("ovr_done_t%0d", t), done0, (t == 4));
      end

      // Reset in the middle of a five-word run
      applyStimulus(22'd100, 22'd16, 16'd5);
      checkOutput("mid_err_cleared", err0, 1'b0);
      inValid = 1'b1;
      inData  = mkWord(1, -3, 0, 0);
      tick();
      inData  = mkWord(2, -4, 0, 0);
      tick();
      rst     = 1'b1;
      inValid = 1'b0;
      tick();
      checkOutput("mid_rst_wr_en", bus0.write_out_ofm_en, 1'b0);
      checkOutput("mid_rst_addr", bus0.ofm_addr_b, 0);
      checkOutput("mid_rst_data", lane(bus0.ofm_data_in, 0), 0);
      checkOutput("mid_rst_in_ready", bus0.in_ready, 1'b0);
      checkOutput("mid_rst_busy", busy0, 1'b0);
      checkOutput("mid_rst_done", done0, 1'b0);
      checkOutput("mid_rst_err", err0, 1'b0);
      rst = 1'b0;
      tick();
      checkOutput("mid_post_wr_en", bus0.write_out_ofm_en, 1'b0);

      applyStimulus(22'd200, 22'd16, 16'd2);
      inValid = 1'b1;
      inData  = mkWord(1, -3, 0, 0);
      for (int t = 1; t <= 5; t++) begin
         tick();
         if (t < 2) inData = mkWord(2, -4, 0, 0);
         else inValid = 1'b0;
         checkOutput($sformatf("rerun_wr_en_t%0d", t), bus0.write_out_ofm_en, (t == 2 || t == 3));
         if (t == 2 || t == 3) begin
            checkOutput($sformatf("rerun_addr_t%0d", t), bus0.ofm_addr_b, 200 + (t - 2) * 16);
            checkOutput($sformatf("rerun_lane0_t%0d", t), lane(bus0.ofm_data_in, 0), t - 1);
         end
         checkOutput($sformatf("rerun_done_t%0d", t), done0, (t == 4));
         if (t == 4) checkOutput("rerun_err", err0, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule

// File: doc/ofm_writeback.md
OFM_WRITEBACK -- requirements
Module: ofm_writeback

Interface
REQ-001 SHALL have parameter SYSTOLIC_SIZE, default 16, the number of lanes per word.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, the signed lane width.
REQ-003 SHALL have parameter INOUT_WIDTH, default 1024, the word width; it equals SYSTOLIC_SIZE*DATA_WIDTH.
REQ-004 SHALL have parameter OFM_RAM_SIZE, default 2378675, the OFM RAM depth in lanes; AW = $clog2(OFM_RAM_SIZE).
REQ-005 SHALL have parameter RELU_PARAM, default 0, the leaky-ReLU shift; 0 selects plain ReLU.
REQ-006 SHALL have ports:
- clk  in  1  clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-high reset; asserted = 1.
- start  in  1  one-cycle pulse; latches the configuration.
- base_addr  in  AW  first OFM address.
- addr_stride  in  AW  address increment per word.
- num_words  in  16  words to write; 0 is legal.
- in_valid  in  1  systolic drain word valid.
- in_data  in  INOUT_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_ready  out  1  block accepts in_data.
- ofm_read_en  in  1  a read owns the RAM port this cycle.
- write_out_ofm_en  out  1  RAM write strobe.
- ofm_addr_b  out  AW  RAM write address.
- ofm_data_in  out  INOUT_WIDTH  RAM write data.
- busy  out  1  not IDLE.
- done  out  1  one-cycle completion pulse.
- addr_err  out  1  sticky overrun flag.

Function
REQ-007 SHALL implement the states IDLE, RUN, DRAIN and DONE.
REQ-008 IDLE->RUN SHALL occur on start with num_words>0; start with num_words=0 SHALL go IDLE->DONE.
REQ-009 RUN->DRAIN SHALL occur the cycle the num_words-th input is accepted.
REQ-010 DRAIN->DONE SHALL occur when the pipeline and FIFO are empty and the last write has issued.
REQ-011 DONE SHALL assert done for exactly 1 cycle and then return to IDLE.
REQ-012 start outside IDLE SHALL be ignored.
REQ-013 An input SHALL be accepted on in_valid && in_ready; in_ready=1 only in RUN while accepted-but-unwritten words (pipeline register plus FIFO) are fewer than 4.
REQ-014 Activation, registered with 1 cycle latency, per lane as a signed value x:
- x>=0 passes unchanged.
- x<0 with RELU_PARAM=0 becomes 0.
- x<0 otherwise becomes x>>>RELU_PARAM (arithmetic shift, sign kept).
REQ-015 Activated words SHALL enter a 4-entry FIFO; simultaneous push and pop SHALL keep occupancy constant, and the FIFO SHALL never overflow.
REQ-016 FIFO head SHALL be written when FIFO is non-empty and ofm_read_en=0: write_out_ofm_en=1 with ofm_data_in=head and ofm_addr_b=current address, registered outputs.
REQ-017 When ofm_read_en=1 the block SHALL issue no write and hold the head (reads have priority).
REQ-018 Word k SHALL be written at base_addr + k*addr_stride; the address register SHALL advance only on an issued write.
REQ-019 Address arithmetic SHALL use AW+1 bits; if address + SYSTOLIC_SIZE > OFM_RAM_SIZE, the block SHALL suppress that write, set addr_err, and continue counting so that done still occurs.
REQ-020 addr_err SHALL clear only on reset or an accepted start.
REQ-021 Minimum latency from accepting word k to its write strobe SHALL be 2 cycles.
REQ-022 Sustained throughput with ofm_read_en=0 SHALL be 1 word/cycle.
REQ-023 Inputs beyond num_words SHALL not be accepted (in_ready=0 in DRAIN).

Reset
REQ-024 With rst_n=1 at a clock edge, the block SHALL reset state=IDLE, FIFO empty, counters 0, address 0, in_ready=0, write_out_ofm_en=0, ofm_addr_b=0, ofm_data_in=0, busy=0, done=0 and addr_err=0.
REQ-025 A reset mid-transfer SHALL discard buffered words, and no write strobe SHALL occur in the cycle after reset.

Verification
REQ-026 Basic run: base=1162176, stride=16, num_words=3, continuous valid, ofm_read_en=0 -> writes at 1162176/1162192/1162208 on consecutive cycles, the first 2 cycles after its accept; done 1 cycle after the last write.
REQ-027 Activation: lanes {5, -8, 0, -1} with RELU_PARAM=0 -> {5, 0, 0, 0}; with RELU_PARAM=2 -> {5, -2, 0, -1}.
REQ-028 Arbitration: ofm_read_en=1 for 6 cycles during a 10-word stream -> no write while high, in_ready falls after 4 words are buffered, all 10 words are written in order with no loss or duplication.
REQ-029 Edge cases: num_words=0 -> done 1 cycle after start with no write. base=OFM_RAM_SIZE-16, stride=16, num_words=2 -> first write issued, second suppressed, addr_err=1, done still asserted.
REQ-030 Reset mid-run: reset after 2 of 5 words -> all outputs 0 next cycle; a new start then completes normally with addr_err=0.
